// File: rtl/period_meter.sv
// Edge-to-edge period / high-time meter for a slow asynchronous input, with stall timeout.
// Optional single-cycle glitch filter enabled by defining PERIOD_METER_DEGLITCH_EN.
module period_meter #(
  parameter int unsigned     CLK_I_SPEED = 100000000,
  parameter int              CNT_W       = 32,
  parameter longint unsigned TIMEOUT_CYC = CLK_I_SPEED
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             timeout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] TO_CYC = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic {WAIT_EDGE, MEASURE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             timeout;
  } result_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             lvl;
  logic             rise;
  logic [CNT_W-1:0] cnt, hi_acc, cnt_inc;
  logic             res_fire, to_hit;
  result_t          res;

`ifdef PERIOD_METER_DEGLITCH_EN
  // s1 is the next s2 sample, so s1 == s2 means two consecutive equal s2 samples.
  logic flt;
  always_ff @(posedge clk_i) begin
    if (rst_i)         flt <= 1'b0;
    else if (s1 == s2) flt <= s2;
  end
  assign lvl = flt;
`else
  assign lvl = s2;
`endif

  assign rise    = lvl & ~s3;
  assign cnt_inc = cnt + ONE;
  assign to_hit  = (state == MEASURE) && !rise && (cnt_inc == TO_CYC);

  always_comb begin
    res_fire = 1'b0;
    res      = '0;
    if (state == MEASURE) begin
      if (rise) begin
        res_fire    = 1'b1;
        res.period  = cnt_inc;
        res.high    = hi_acc;
        res.timeout = 1'b0;
      end else if (to_hit) begin
        res_fire    = 1'b1;
        res.period  = TO_CYC;
        res.high    = hi_acc;
        res.timeout = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= WAIT_EDGE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      hi_acc    <= '0;
      period_o  <= '0;
      high_o    <= '0;
      timeout_o <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      s1 <= sig_i;
      s2 <= s1;
      s3 <= lvl;

      unique case (state)
        WAIT_EDGE: begin
          if (rise) begin
            state  <= MEASURE;
            cnt    <= '0;
            hi_acc <= ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt    <= '0;
            hi_acc <= ONE;
          end else if (to_hit) begin
            state  <= WAIT_EDGE;
            cnt    <= '0;
            hi_acc <= '0;
          end else begin
            cnt    <= cnt_inc;
            hi_acc <= hi_acc + CNT_W'(lvl);
          end
        end
        default: state <= WAIT_EDGE;
      endcase

      // A new result may replace a held one only in the cycle it is being transferred.
      if (valid_o && ready_i) valid_o <= 1'b0;
      if (res_fire) begin
        if (!valid_o || ready_i) begin
          period_o  <= res.period;
          high_o    <= res.high;
          timeout_o <= res.timeout;
          valid_o   <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square waves, back-pressure, timeout, reset, same-cycle load.
module tb_period_meter;

`ifdef PERIOD_METER_DEGLITCH_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i, sig_i, ready_i;
  logic [CNT_W-1:0] period_o, high_o;
  logic             timeout_o, valid_o, overrun_o;

  int n_checks = 0;
  int n_err    = 0;

  // values sampled one cycle before and at the expected result edge of a wave
  logic             pre_v, pre_ov, r_v, r_t, r_ov;
  logic [CNT_W-1:0] r_p, r_h;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(50)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sig_i    (sig_i),
    .period_o (period_o),
    .high_o   (high_o),
    .timeout_o(timeout_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One input period of p cycles, high for hi cycles; optionally raise ready_i
  // just in time for the result edge of this wave.
  task automatic wave(input int p, input int hi, input bit rdy_set);
    sig_i = 1'b1;
    for (int i = 0; i < p; i++) begin
      if (i == hi) sig_i = 1'b0;
      step(1);
      if (i == LAT - 1) begin
        pre_v  = valid_o;
        pre_ov = overrun_o;
        if (rdy_set) ready_i = 1'b1;
      end
      if (i == LAT) begin
        r_v  = valid_o;
        r_p  = period_o;
        r_h  = high_o;
        r_t  = timeout_o;
        r_ov = overrun_o;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; sig_i = 1'b0; ready_i = 1'b1;
    step(2);
    chk("rst_valid", valid_o, 0);
    chk("rst_period", period_o, 0);
    chk("rst_overrun", overrun_o, 0);
    rst_i = 1'b0;
    step(3);

    // 50% duty, period 10, ready held high
    wave(10, 5, 0);
    chk("arm_no_result", r_v, 0);
    wave(10, 5, 0);
    chk("sq_latency_pre", pre_v, 0);
    chk("sq_valid", r_v, 1);
    chk("sq_period", r_p, 10);
    chk("sq_high", r_h, 5);
    chk("sq_timeout", r_t, 0);
    wave(10, 5, 0);
    chk("sq2_period", r_p, 10);

    // 25% duty, period 8, back-pressure for three periods
    wave(8, 2, 0);
    chk("q_prev_high", r_h, 5);
    ready_i = 1'b0;
    wave(8, 2, 0);
    chk("q_valid", r_v, 1);
    chk("q_period", r_p, 8);
    chk("q_high", r_h, 2);
    chk("q_no_ovr", r_ov, 0);
    wave(8, 2, 0);
    chk("q_ovr_pre", pre_ov, 0);
    chk("q_ovr_set", r_ov, 1);
    chk("q_held_period", r_p, 8);
    wave(8, 2, 0);
    chk("q_held_valid", valid_o, 1);
    chk("q_held_period2", period_o, 8);
    chk("q_held_high2", high_o, 2);
    ready_i = 1'b1;
    step(1);
    chk("q_xfer_valid", valid_o, 0);
    chk("q_ovr_sticky", overrun_o, 1);

    // reset mid-period with a held result
    ready_i = 1'b0;
    wave(8, 2, 0);
    chk("r_pre_period", r_p, 9);
    sig_i = 1'b1;
    step(4);
    chk("r_pre_valid", valid_o, 1);
    rst_i = 1'b1; sig_i = 1'b0; ready_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("r_valid", valid_o, 0);
    chk("r_period", period_o, 0);
    chk("r_high", high_o, 0);
    chk("r_timeout", timeout_o, 0);
    chk("r_overrun", overrun_o, 0);
    step(3);
    wave(10, 5, 0);
    chk("r_arm_only", r_v, 0);
    wave(10, 5, 0);
    chk("r_meas_valid", r_v, 1);
    chk("r_meas_period", r_p, 10);

    // new result in the same cycle as a transfer
    ready_i = 1'b0;
    wave(10, 3, 0);
    chk("s_held_high", r_h, 5);
    wave(10, 5, 1);
    chk("s_pre_valid", pre_v, 1);
    chk("s_valid", r_v, 1);
    chk("s_new_high", r_h, 3);
    chk("s_no_ovr", r_ov, 0);

    // input stalls low: one timeout result, then silence until re-armed
    step(LAT + 40);
    chk("t_before", valid_o, 0);
    step(1);
    chk("t_valid", valid_o, 1);
    chk("t_flag", timeout_o, 1);
    chk("t_period", period_o, 50);
    chk("t_high", high_o, 5);
    step(1);
    chk("t_xfer", valid_o, 0);
    step(100);
    chk("t_silent", valid_o, 0);
    wave(10, 5, 0);
    chk("t_rearm_only", r_v, 0);
    wave(10, 5, 0);
    chk("t_meas_valid", r_v, 1);
    chk("t_meas_period", r_p, 10);
    chk("t_meas_flag", r_t, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous square-wave input, such as a divided clock or an external tick, in cycles of the system clock. It reports each completed period through a valid/ready result port. It is the observing end of the clock-divider path: it checks divider outputs on hardware and feeds rate and duty information to control logic. Measurement runs continuously, edge to edge, with a timeout for stalled inputs.

## Interface
Parameters:
- CLK_I_SPEED, 100000000: system clock rate in Hz; only used for the TIMEOUT_CYC default.
- CNT_W, 32: width of the counters and of the result fields.
- TIMEOUT_CYC, CLK_I_SPEED: number of cycles without a rising edge before a timeout result is emitted; must be in the range 2 to 2^CNT_W−1.

Ports (one clock; reset is synchronous and active-high):
- clk_i, input, 1: system clock.
- rst_i, input, 1: synchronous, active-high reset.
- sig_i, input, 1: measured signal, asynchronous to clk_i.
- period_o, output, CNT_W: cycles between two successive rising edges.
- high_o, output, CNT_W: cycles the filtered signal was high within that period.
- timeout_o, output, 1: the current result is a timeout rather than a measured period.
- valid_o, output, 1: a result is held on the output.
- ready_i, input, 1: the consumer accepts the result.
- overrun_o, output, 1: sticky flag; a result was dropped.

## Operation
- sig_i passes through a 2-flop synchronizer (s1, s2), then s3 is a delayed copy of s2. A rising edge is defined as s2 & ~s3.
- States:
  - WAIT_EDGE (reset state): counters idle; the first rising edge moves to MEASURE and produces no result.
  - MEASURE, on a rising edge:
    - produce a result with period = cnt+1, high = hi_acc, timeout = 0.
    - set cnt to 0 and hi_acc to 1, and stay in MEASURE.
  - MEASURE, between edges:
    - cnt += 1 each cycle.
    - hi_acc += s2 each cycle.
  - MEASURE, when cnt+1 == TIMEOUT_CYC with no edge in that cycle:
    - produce a result with period = TIMEOUT_CYC, high = hi_acc, timeout = 1.
    - move to WAIT_EDGE.
- Producing a result:
  - If valid_o is 0, or valid_o and ready_i are both 1, load the output registers and set valid_o to 1.
  - Otherwise drop the result, keep the held values and set overrun_o to 1.
- Handshake:
  - A transfer occurs on a cycle where valid_o & ready_i.
  - After a transfer with no new result, valid_o = 0.
  - Outputs are stable while valid_o & ~ready_i.
- Simultaneous events:
  - Edge and timeout in the same cycle: the edge wins and a normal result is produced.
  - New result and transfer in the same cycle: the new result loads, valid_o stays 1, and there is no overrun.
- Reset values: all outputs 0, state WAIT_EDGE, s1, s2, s3, cnt and hi_acc all 0, overrun_o cleared. Only rst_i clears overrun_o.
- Reset mid-measurement discards the partial count.
- Because the synchronizer resets to 0, a sig_i held high through reset shows an edge 2 cycles after reset. That edge only arms the meter.
- Arithmetic: counters are unsigned CNT_W bits. cnt cannot wrap because the timeout bounds it. hi_acc ≤ cnt+1.

## Timing
- Signal to edge: a sig_i rise sampled at clk edge k gives s1 = 1 at k and s2 = 1 at k+1, so the edge is detected in the cycle after k+1.
- Result latency: valid_o and the result fields update at clk edge k+2, i.e. 2 cycles after the sampled edge of sig_i.
- Timeout latency: valid_o asserts at the clock edge where cnt would reach TIMEOUT_CYC, counted from the last detected edge.
- Resolution is ±1 cycle for asynchronous inputs.
- Throughput: one result per input period; periods ≥ 2 cycles are supported.
- All outputs are registered.

## Configuration
- PERIOD_METER_DEGLITCH_EN defined:
  - A majority filter sits after s2: the filtered level changes only after 2 consecutive equal s2 samples.
  - Single-cycle glitches are ignored.
  - Edge detection and hi_acc use the filtered level.
  - Every latency increases by 1 cycle.
  - The minimum supported period becomes 4 cycles.
- PERIOD_METER_DEGLITCH_EN undefined: no filter; behaviour is exactly as described above.

## Test plan
- Square wave, period 10 cycles, 50% duty, ready_i held 1 → the first edge gives no result; each later edge gives period_o=10, high_o=5, timeout_o=0, with valid_o asserting 2 cycles after the sampled rise.
- 25% duty, period 8, with ready_i held 0 for 3 periods → the first result (8, 2) holds stable, overrun_o=1 after the second edge, and the held result is unchanged until ready_i=1.
- TIMEOUT_CYC=50; edges, then sig_i stuck low → one result with period_o=50 and timeout_o=1; no further results until the next edge arms and the one after it measures.
- A result completes in the same cycle as valid_o & ready_i → the new result loads, valid_o stays 1, overrun_o stays 0.
- rst_i asserted for 1 cycle mid-period with valid_o=1 → the next cycle shows all outputs 0 and state WAIT_EDGE; the next two edges are needed for a result.
- With PERIOD_METER_DEGLITCH_EN, a period-10 wave with a 1-cycle low glitch inside the high phase → period_o=10, the glitch produces no edge, and latency is 3 cycles.
